mdu_iter: RTL



---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mdu_iter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        ZDIV = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, purely combinational.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = en_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit sharing one shift/add datapath.
import mdu_pkg::*;

module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic               div_by_zero_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    res_q, res_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic             nsgn_q, nsgn_d;
    logic             rsgn_q, rsgn_d;
    logic             dbz_q, dbz_d;

    logic             s1, s2, accept, zdiv;
    logic [WIDTH-1:0] mag1, mag2;

    assign s1     = is_signed(op_i) & opdata1_i[WIDTH-1];
    assign s2     = is_signed(op_i) & opdata2_i[WIDTH-1];
    assign accept = start_i & ~annul_i
                  & ((state_q == IDLE) | (state_q == DONE));
    assign zdiv   = is_div(op_i) & (opdata2_i == '0);

    mdu_negate #(.W(WIDTH)) u_mag1 (.en_i(s1), .a_i(opdata1_i), .y_o(mag1));
    mdu_negate #(.W(WIDTH)) u_mag2 (.en_i(s2), .a_i(opdata2_i), .y_o(mag2));

    // Multiply: hi accumulates, lo holds the multiplier shifting out.
    logic [WIDTH:0] msum;
    logic [W2-1:0]  mul_nxt;

    assign msum    = {1'b0, acc_q[W2-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   dshift;
    logic [WIDTH+1:0] dtrial;
    logic             qbit;
    logic [WIDTH-1:0] drem;
    logic [W2-1:0]    div_nxt;
    logic             unused_ok;

    assign dshift    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign dtrial    = {1'b0, dshift} - {2'b00, opb_q};
    assign qbit      = ~dtrial[WIDTH+1];
    assign drem      = qbit ? dtrial[WIDTH-1:0] : dshift[WIDTH-1:0];
    assign div_nxt   = {drem, acc_q[WIDTH-2:0], qbit};
    assign unused_ok = dtrial[WIDTH];

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;
    logic [W2-1:0]    fix_res;

    mdu_negate #(.W(W2)) u_prod (
        .en_i(nsgn_q), .a_i(acc_q), .y_o(prod)
    );
    mdu_negate #(.W(WIDTH)) u_quo (
        .en_i(nsgn_q), .a_i(acc_q[WIDTH-1:0]), .y_o(quo)
    );
    mdu_negate #(.W(WIDTH)) u_rem (
        .en_i(rsgn_q), .a_i(acc_q[W2-1:WIDTH]), .y_o(rem)
    );

    assign fix_res = div_q ? {rem, quo} : prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        opb_d   = opb_q;
        div_d   = div_q;
        nsgn_d  = nsgn_q;
        rsgn_d  = rsgn_q;
        dbz_d   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    div_d  = is_div(op_i);
                    cnt_d  = '0;
                    nsgn_d = s1 ^ s2;
                    rsgn_d = s1;
                    opb_d  = mag2;
                    if (zdiv) begin
                        state_d = ZDIV;
                        acc_d   = {opdata1_i, {WIDTH{1'b1}}};
                    end else begin
                        state_d = CALC;
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                    end
                end
            end
            CALC: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = div_q ? div_nxt : mul_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = DONE;
                end
            end
            ZDIV: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    res_d   = acc_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            nsgn_q  <= 1'b0;
            rsgn_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            nsgn_q  <= nsgn_d;
            rsgn_q  <= rsgn_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q == CALC) | (state_q == FIX)
                         | (state_q == ZDIV);
    assign ready_o       = (state_q == DONE);
    assign div_by_zero_o = dbz_q;
    assign result_o      = res_q;

endmodule
